// File: rtl/queue_op_sched.sv
// Round-robin arbiter serialising push/pop/remove/modify ops onto one queue.
// Define QUEUE_OP_SCHED_POP_PRIO_EN to give pending pops strict priority.
module queue_op_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int DATA_SIZE = 64,
    parameter int PTR_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ*PTR_WIDTH-1:0]   req_index,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [1:0]                     rsp_status,
    output logic [DATA_SIZE-1:0]           rsp_data,
    output logic [2:0]                     q_op_flag,
    output logic [PTR_WIDTH-1:0]           q_op_index,
    output logic [DATA_SIZE-1:0]           q_op_data,
    input  logic [DATA_SIZE-1:0]           q_pop_data,
    input  logic                           q_full,
    input  logic                           q_empty,
    input  logic                           q_error_rem,
    input  logic                           q_error_time
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CHECK
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_CAP   = 2'b01;
    localparam logic [1:0] ST_BADIX = 2'b10;
    localparam logic [1:0] ST_NRDY  = 2'b11;

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        cur_id;
    logic [1:0]             cur_op;
    logic [PTR_WIDTH-1:0]   cur_index;
    logic [DATA_SIZE-1:0]   cur_data;
    logic [DATA_SIZE-1:0]   pop_buf;

    logic [NUM_REQ-1:0]     cand;
    logic [NUM_REQ-1:0]     pop_mask;
    logic [ID_W-1:0]        arb_idx;
    logic [ID_W-1:0]        win_id;
    logic                   win_found;
    logic [1:0]             sel_op;
    logic [PTR_WIDTH-1:0]   sel_index;
    logic [DATA_SIZE-1:0]   sel_data;
    logic                   cap_fail;

    always_comb begin
        pop_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_mask[i] = req_valid[i] && (req_op[2*i +: 2] == OP_POP);
        end
    end

`ifdef QUEUE_OP_SCHED_POP_PRIO_EN
    assign cand = (|pop_mask) ? pop_mask : req_valid;
`else
    assign cand = req_valid;
`endif

    // First candidate at or after rr_ptr, wrapping in id order.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = rr_ptr + ID_W'(i);
            if (!win_found && cand[arb_idx]) begin
                win_found = 1'b1;
                win_id    = arb_idx;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_index = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                sel_op    = req_op[2*i +: 2];
                sel_index = req_index[i*PTR_WIDTH +: PTR_WIDTH];
                sel_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign req_ready = (state == IDLE && win_found)
                     ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_id)
                     : '0;

    // Pre-check keeps the queue's sticky overflow/underflow flag clear.
    assign cap_fail = ((cur_op == OP_PUSH) && q_full)
                   || ((cur_op == OP_POP) && q_empty);

    assign q_op_flag  = (state == ISSUE && !cap_fail)
                      ? {1'b1, cur_op} : 3'b000;
    assign q_op_index = (state != IDLE) ? cur_index : '0;
    assign q_op_data  = (state != IDLE) ? cur_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            cur_op     <= '0;
            cur_index  <= '0;
            cur_data   <= '0;
            pop_buf    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_status <= ST_OK;
            rsp_data   <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_status <= ST_OK;
            rsp_data   <= '0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        cur_id    <= win_id;
                        cur_op    <= sel_op;
                        cur_index <= sel_index;
                        cur_data  <= sel_data;
                        rr_ptr    <= win_id + ID_W'(1);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cap_fail) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_status <= ST_CAP;
                        state      <= IDLE;
                    end else begin
                        pop_buf <= q_pop_data;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    state     <= IDLE;
                    if (cur_op == OP_POP) begin
                        if (q_error_time) begin
                            rsp_status <= ST_NRDY;
                        end else begin
                            rsp_data <= pop_buf;
                        end
                    end else if (cur_op != OP_PUSH) begin
                        rsp_status <= q_error_rem ? ST_BADIX : ST_OK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
